// File: rtl/leve1_csr_seq.sv
// rtl/leve1_csr_seq.sv - Zicsr instruction sequencer in front of the CSR register file.
// Optional privilege check: define LEVE_CSR_PRIV_CHECK_EN.
module leve1_csr_seq #(
  parameter int XLEN = 64
) (
  input  logic            CLK,
  input  logic            RSTn,
  input  logic            REQ_VALID,
  output logic            REQ_READY,
  input  logic [2:0]      REQ_OP,
  input  logic [11:0]     REQ_CSR,
  input  logic [XLEN-1:0] REQ_RS1,
  input  logic [4:0]      REQ_UIMM,
  input  logic            REQ_RD_NZ,
  input  logic [1:0]      MODE,
  output logic [11:0]     CSR_RA,
  input  logic [XLEN-1:0] CSR_RD,
  output logic [1:0]      CSR_WCMD,
  output logic [11:0]     CSR_WA,
  output logic [XLEN-1:0] CSR_WD,
  output logic            RSP_VALID,
  input  logic            RSP_READY,
  output logic [XLEN-1:0] RSP_DATA,
  output logic            RSP_ILLEGAL,
  output logic            RETIRE
);

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2, RESP = 2'd3} state_t;

  localparam logic [1:0] CSR_NONE = 2'd0;
  localparam logic [1:0] CSR_W    = 2'd1;
  localparam logic [1:0] CSR_S    = 2'd2;
  localparam logic [1:0] CSR_C    = 2'd3;

  state_t          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [11:0]     csr_q, csr_d;
  logic [XLEN-1:0] operand_q, operand_d;
  logic            wr_en_q, wr_en_d;
  logic            rd_nz_q, rd_nz_d;
  logic [1:0]      mode_q, mode_d;
  logic [XLEN-1:0] rsp_data_q, rsp_data_d;
  logic            rsp_ill_q, rsp_ill_d;

  logic [XLEN-1:0] operand_in;
  logic            wr_en_in;
  logic [XLEN-1:0] new_val;
  logic            priv_fail;
  logic            illegal;

  assign operand_in = REQ_OP[2] ? {{(XLEN-5){1'b0}}, REQ_UIMM} : REQ_RS1;
  // RW/RWI always write; set/clear forms write only when the source field is nonzero.
  assign wr_en_in   = (REQ_OP[1:0] == 2'b01) || (REQ_UIMM != 5'd0);

`ifdef LEVE_CSR_PRIV_CHECK_EN
  assign priv_fail = (csr_q[9:8] > mode_q);
`else
  logic unused_mode;
  assign priv_fail   = 1'b0;
  assign unused_mode = ^mode_q;
`endif

  assign illegal = (op_q[1:0] == 2'b00) || (wr_en_q && (csr_q[11:10] == 2'b11)) || priv_fail;

  always_comb begin
    new_val = operand_q;
    case (op_q[1:0])
      2'b01:   new_val = operand_q;
      2'b10:   new_val = CSR_RD | operand_q;
      default: new_val = CSR_RD & ~operand_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    csr_d      = csr_q;
    operand_d  = operand_q;
    wr_en_d    = wr_en_q;
    rd_nz_d    = rd_nz_q;
    mode_d     = mode_q;
    rsp_data_d = rsp_data_q;
    rsp_ill_d  = rsp_ill_q;
    REQ_READY  = 1'b0;
    CSR_WCMD   = CSR_NONE;
    CSR_WA     = '0;
    CSR_WD     = '0;
    RSP_VALID  = 1'b0;
    RETIRE     = 1'b0;
    case (state_q)
      IDLE: begin
        REQ_READY = 1'b1;
        if (REQ_VALID) begin
          op_d      = REQ_OP;
          csr_d     = REQ_CSR;
          operand_d = operand_in;
          wr_en_d   = wr_en_in;
          rd_nz_d   = REQ_RD_NZ;
          mode_d    = MODE;
          state_d   = READ;
        end
      end
      READ: state_d = WRITE;
      WRITE: begin
        // CSR_RD carries the old value this cycle; the write is single-cycle.
        if (!illegal && wr_en_q) begin
          case (op_q[1:0])
            2'b01:   CSR_WCMD = CSR_W;
            2'b10:   CSR_WCMD = CSR_S;
            default: CSR_WCMD = CSR_C;
          endcase
          CSR_WA = csr_q;
          CSR_WD = new_val;
        end
        rsp_data_d = rd_nz_q ? CSR_RD : '0;
        rsp_ill_d  = illegal;
        state_d    = RESP;
      end
      RESP: begin
        RSP_VALID = 1'b1;
        if (RSP_READY) begin
          RETIRE  = !rsp_ill_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q    <= IDLE;
      op_q       <= '0;
      csr_q      <= '0;
      operand_q  <= '0;
      wr_en_q    <= 1'b0;
      rd_nz_q    <= 1'b0;
      mode_q     <= '0;
      rsp_data_q <= '0;
      rsp_ill_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      csr_q      <= csr_d;
      operand_q  <= operand_d;
      wr_en_q    <= wr_en_d;
      rd_nz_q    <= rd_nz_d;
      mode_q     <= mode_d;
      rsp_data_q <= rsp_data_d;
      rsp_ill_q  <= rsp_ill_d;
    end
  end

  assign CSR_RA      = csr_q;
  assign RSP_DATA    = rsp_data_q;
  assign RSP_ILLEGAL = rsp_ill_q;

endmodule
